// File: rtl/div_unit.sv
// Multi-cycle signed restoring divider (MIPS div semantics): one quotient bit per
// clock, sign fix-up in a final cycle, and a one-cycle done pulse on completion.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0]         CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [DATA_WIDTH-1:0]   acc_q;
    logic [DATA_WIDTH-1:0]   rem_q;
    logic [DATA_WIDTH-1:0]   dvs_q;
    logic                    sgn_dvd_q;
    logic                    sgn_dvs_q;
    logic [DATA_WIDTH-1:0]   quotient_q;
    logic [DATA_WIDTH-1:0]   remainder_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    div_zero_q;
    logic [DATA_WIDTH:0]     trial_s;
    logic [DATA_WIDTH-1:0]   acc_d;
    logic [DATA_WIDTH-1:0]   rem_d;

    function automatic logic [DATA_WIDTH-1:0] neg(input logic [DATA_WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    // Magnitude of a two's-complement value; the most negative value maps to itself as unsigned.
    function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? neg(v) : v;
    endfunction

    // One restoring step: the partial remainder never reaches 2^(W-1), so its top bit is dropped.
    always_comb begin
        trial_s = {1'b0, rem_q[DATA_WIDTH-2:0], acc_q[DATA_WIDTH-1]} - {1'b0, dvs_q};
        acc_d   = acc_q;
        rem_d   = rem_q;
        if (!trial_s[DATA_WIDTH]) begin
            rem_d = trial_s[DATA_WIDTH-1:0];
            acc_d = {acc_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_d = {rem_q[DATA_WIDTH-2:0], acc_q[DATA_WIDTH-1]};
            acc_d = {acc_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM with all datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CW{1'b0}};
            acc_q       <= ZERO;
            rem_q       <= ZERO;
            dvs_q       <= ZERO;
            sgn_dvd_q   <= 1'b0;
            sgn_dvs_q   <= 1'b0;
            quotient_q  <= ZERO;
            remainder_q <= ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (divisor == ZERO) begin
                            // Results are left untouched; only the flag reports the fault.
                            div_zero_q <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            acc_q      <= mag(dividend);
                            dvs_q      <= mag(divisor);
                            sgn_dvd_q  <= dividend[DATA_WIDTH-1];
                            sgn_dvs_q  <= divisor[DATA_WIDTH-1];
                            rem_q      <= ZERO;
                            cnt_q      <= {CW{1'b0}};
                            div_zero_q <= 1'b0;
                            state_q    <= S_CALC;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_SIGN;
                    end else begin
                        state_q <= S_CALC;
                    end
                end
                S_SIGN: begin
                    quotient_q  <= (sgn_dvd_q ^ sgn_dvs_q) ? neg(acc_q) : acc_q;
                    remainder_q <= sgn_dvd_q ? neg(rem_q) : rem_q;
                    done_q      <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases with literal expectations plus
// randomized traffic checked every cycle against a cycle-count/arithmetic model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Model: cycles left until idle, visible results, pending result of the running op.
    int          m_left = 0;
    logic [31:0] m_q = 32'd0;
    logic [31:0] m_r = 32'd0;
    logic        m_z = 1'b0;
    logic [31:0] p_q = 32'd0;
    logic [31:0] p_r = 32'd0;
    bit          p_valid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
    endfunction

    always @(posedge clk) begin
        if (reset !== 1'b1) begin
            m_left  = 0;
            m_q     = 32'd0;
            m_r     = 32'd0;
            m_z     = 1'b0;
            p_valid = 1'b0;
        end else if (m_left == 0) begin
            if (start === 1'b1) begin
                if (divisor == 32'd0) begin
                    m_z     = 1'b1;
                    m_left  = 1;
                    p_valid = 1'b0;
                end else begin
                    m_z     = 1'b0;
                    ref_div(dividend, divisor, p_q, p_r);
                    p_valid = 1'b1;
                    m_left  = 34;
                end
            end
        end else begin
            m_left--;
            if (m_left == 1 && p_valid) begin
                m_q = p_q;
                m_r = p_r;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc busy", 32'(busy), 32'(m_left > 0));
            chk("cyc done", 32'(done), 32'(m_left == 1));
            chk("cyc quotient", quotient, m_q);
            chk("cyc remainder", remainder, m_r);
            chk("cyc div_zero", 32'(div_zero), 32'(m_z));
        end
    end

    // Call right after a falling edge; returns at a falling edge.
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic ez,
                          input int lat, input bit repulse);
        int k;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start    = 1'b0;
                dividend = $urandom;
                divisor  = $urandom;
            end
            if (repulse && k == 4) begin
                start    = 1'b1;
                dividend = 32'd1000;
                divisor  = 32'd3;
            end
            if (repulse && k == 5) start = 1'b0;
            if (done === 1'b1) break;
        end
        chk({nm, " latency"}, 32'(k), 32'(lat));
        chk({nm, " quotient"}, quotient, eq);
        chk({nm, " remainder"}, remainder, er);
        chk({nm, " div_zero"}, 32'(div_zero), 32'(ez));
        @(negedge clk);
        chk({nm, " done low after"}, 32'(done), 32'd0);
        chk({nm, " busy low after"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        chk("reset quotient", quotient, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("7/2", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 34, 1'b0);
        run_op("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 1'b0);
        run_op("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 1'b0);
        run_op("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, 1'b0);
        run_op("5/9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 34, 1'b0);
        run_op("prior 7/2", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 34, 1'b0);
        run_op("7/0", 32'd7, 32'd0, 32'd3, 32'd1, 1'b1, 1, 1'b0);
        run_op("clear dz", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 34, 1'b0);
        run_op("repulse", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1'b1);

        // Abort with reset sampled at E10.
        dividend = 32'd7;
        divisor  = 32'd2;
        start    = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        chk("abort quotient", quotient, 32'd0);
        chk("abort remainder", remainder, 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("abort no done", 32'(done), 32'd0);
        end
        run_op("after abort", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1'b0);

        // Reset wins over a simultaneous start.
        reset    = 1'b0;
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd4;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        chk("rst prio busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rst prio idle", 32'(busy), 32'd0);

        // Random traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            dividend = pick();
            divisor  = pick();
            reset    = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
